// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker for the 6-stage Fibonacci LFSR (taps 5,4).
// Optional LFSR_CHK_ZERO_DETECT_EN adds dead-zero rejection and a sticky `stuck` output.
module lfsr_prbs_checker #(
  parameter int LOCK_CNT   = 12,
  parameter int ERR_THRESH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             locked,
  output logic             err,
`ifdef LFSR_CHK_ZERO_DETECT_EN
  output logic             stuck,
`endif
  output logic [CNT_W-1:0] err_count
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam int EW    = $clog2(ERR_THRESH + 1);

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [5:0]       hist_q, hist_d;
  logic [2:0]       fill_q, fill_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [5:0]       lfsr_q, lfsr_d;
  logic [5:0]       window_q, window_d;
  logic [EW-1:0]    err_win_q, err_win_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;
`ifdef LFSR_CHK_ZERO_DETECT_EN
  logic [2:0]       zrun_q, zrun_d;
  logic             stuck_q, stuck_d;
`endif

  logic             pred_hist, pred_lfsr, hit, miss;
  logic [5:0]       hist_shift;
  logic [RUN_W-1:0] run_inc;
  logic [EW-1:0]    err_win_inc;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_d      = fill_q;
    run_d       = run_q;
    lfsr_d      = lfsr_q;
    window_d    = window_q;
    err_win_d   = err_win_q;
    err_d       = 1'b0;
    err_count_d = err_count_q;
`ifdef LFSR_CHK_ZERO_DETECT_EN
    zrun_d      = zrun_q;
    stuck_d     = stuck_q;
`endif
    pred_hist   = hist_q[5] ^ hist_q[4];
    pred_lfsr   = lfsr_q[5] ^ lfsr_q[4];
    hist_shift  = {hist_q[4:0], in_bit};
    run_inc     = run_q + 1'b1;
    err_win_inc = err_win_q + 1'b1;
    hit         = (pred_hist == in_bit);
`ifdef LFSR_CHK_ZERO_DETECT_EN
    hit         = hit && (hist_q != 6'd0);
`endif
    miss        = (in_bit != pred_lfsr);

    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          hist_d = hist_shift;
          if (fill_q != 3'd6) begin
            fill_d = fill_q + 3'd1;
          end else if (!hit) begin
            run_d = '0;
          end else if (run_inc == RUN_W'(LOCK_CNT)) begin
            // The bit that completes the run is already part of the loaded state.
            state_d   = LOCKED;
            lfsr_d    = hist_shift;
            run_d     = '0;
            window_d  = '0;
            err_win_d = '0;
`ifdef LFSR_CHK_ZERO_DETECT_EN
            zrun_d    = '0;
`endif
          end else begin
            run_d = run_inc;
          end
        end
        LOCKED: begin
          // Free-running: the received bit never feeds the local LFSR.
          lfsr_d = {lfsr_q[4:0], pred_lfsr};
          if (miss) begin
            err_d     = 1'b1;
            err_win_d = err_win_inc;
            if (err_count_q != {CNT_W{1'b1}}) err_count_d = err_count_q + 1'b1;
          end
          if (miss && (err_win_inc == EW'(ERR_THRESH))) begin
            state_d = SEARCH;
            fill_d  = '0;
            run_d   = '0;
            hist_d  = '0;
          end else if (window_q == 6'd62) begin
            window_d  = '0;
            err_win_d = '0;
          end else begin
            window_d = window_q + 6'd1;
          end
`ifdef LFSR_CHK_ZERO_DETECT_EN
          if (in_bit) begin
            zrun_d = '0;
          end else begin
            if (zrun_q == 3'd5) stuck_d = 1'b1;
            else                zrun_d  = zrun_q + 3'd1;
          end
`endif
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clr) err_count_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= SEARCH;
      hist_q      <= '0;
      fill_q      <= '0;
      run_q       <= '0;
      lfsr_q      <= '0;
      window_q    <= '0;
      err_win_q   <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
`ifdef LFSR_CHK_ZERO_DETECT_EN
      zrun_q      <= '0;
      stuck_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      run_q       <= run_d;
      lfsr_q      <= lfsr_d;
      window_q    <= window_d;
      err_win_q   <= err_win_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
`ifdef LFSR_CHK_ZERO_DETECT_EN
      zrun_q      <= zrun_d;
      stuck_q     <= stuck_d;
`endif
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_count = err_count_q;
`ifdef LFSR_CHK_ZERO_DETECT_EN
  assign stuck     = stuck_q;
`endif

endmodule
